// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared constants and types for the CNN image loader slice.
//   DATA_W     : width of one pixel word
//   IMG_PIXELS : words per frame (IMG_DIM x IMG_DIM, row-major)
//   CNT_W      : width of the per-frame word counter
//   loader_state_t : dispatch FSM encodings (IDLE / START / WAIT)
// ---------------------------------------------------------------------------
package cnn_pkg;

   localparam int DATA_W     = 32;
   localparam int IMG_DIM    = 8;
   localparam int IMG_PIXELS = IMG_DIM * IMG_DIM;
   localparam int CNT_W      = $clog2(IMG_PIXELS);

   typedef enum logic [1:0] {
      LD_IDLE  = 2'd0,
      LD_START = 2'd1,
      LD_WAIT  = 2'd2
   } loader_state_t;

endpackage

// File: rtl/cnn_img_bank.sv
// ---------------------------------------------------------------------------
// cnn_img_bank
// One IMG_PIXELS x DATA_W register bank. Single write port, and every word
// is visible at once on a flat read bus.
// Ports:
//   clk    : clock
//   i_we   : write enable
//   i_addr : word index to write
//   i_data : word to write
//   o_img  : flat image, word i at bits [i*DATA_W +: DATA_W]
// Contents are not reset; a bank is only read after it has been filled.
// ---------------------------------------------------------------------------
module cnn_img_bank
   import cnn_pkg::*;
(
   input  logic                         clk,
   input  logic                         i_we,
   input  logic [CNT_W-1:0]             i_addr,
   input  logic [DATA_W-1:0]            i_data,
   output logic [IMG_PIXELS*DATA_W-1:0] o_img
);

   logic [DATA_W-1:0] r_mem [IMG_PIXELS];

   // Store the incoming word at its pixel position.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_data;
      end
   end

   // Flatten the storage so the core sees the whole frame in parallel.
   for (genvar g = 0; g < IMG_PIXELS; g++) begin : g_flat
      assign o_img[g*DATA_W +: DATA_W] = r_mem[g];
   end

endmodule

// File: rtl/cnn_img_loader.sv
// ---------------------------------------------------------------------------
// cnn_img_loader
// Ping-pong frame loader in front of the CNN core. One bank fills from the
// valid/ready pixel stream while the other is presented to the core.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last : pixel stream (row-major, pixel 0 first)
//   img_out      : flat image of the dispatched bank
//   core_enable  : one-cycle start pulse to the core
//   core_done    : one-cycle completion pulse from the core
//   busy         : a frame is dispatched and awaiting core_done
//   frame_cnt    : frames completed by the core (wraps)
//   frame_err    : sticky frame-length error flag
// Build option:
//   CNN_LOADER_LAST_CHECK_EN : checks s_last against the frame length.
//   Without it s_last is ignored and frame_err is tied low.
// ---------------------------------------------------------------------------
module cnn_img_loader
   import cnn_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [DATA_W-1:0]            s_data,
   input  logic                         s_last,
   output logic [IMG_PIXELS*DATA_W-1:0] img_out,
   output logic                         core_enable,
   input  logic                         core_done,
   output logic                         busy,
   output logic [15:0]                  frame_cnt,
   output logic                         frame_err
);

   localparam int               IMG_W    = IMG_PIXELS * DATA_W;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_PIXELS - 1);

   loader_state_t    r_state;
   logic [1:0]       r_full;
   logic             r_wr_bank;
   logic             r_rd_bank;
   logic [CNT_W-1:0] r_wr_cnt;
   logic             r_s_ready;
   logic             r_core_enable;
   logic             r_busy;
   logic [15:0]      r_frame_cnt;
   logic [IMG_W-1:0] r_img_out;

   logic [IMG_W-1:0] w_img0;
   logic [IMG_W-1:0] w_img1;
   logic             w_xfer;
   logic             w_at_last;
   logic             w_abort;
   logic             w_release;
   logic             w_dispatch;
   logic             w_sel_bank;
   logic [1:0]       w_full_next;
   logic             w_wr_bank_next;
   logic [CNT_W-1:0] w_wr_cnt_next;

   assign w_xfer     = s_valid && r_s_ready;
   assign w_at_last  = (r_wr_cnt == LAST_IDX);
   assign w_release  = (r_state == LD_WAIT) && core_done;
   assign w_dispatch = (r_state == LD_IDLE) && (|r_full);
   // Prefer the bank not being written; it is the older of the two.
   assign w_sel_bank = r_full[~r_wr_bank] ? ~r_wr_bank : r_wr_bank;

`ifdef CNN_LOADER_LAST_CHECK_EN
   logic r_frame_err;
   logic w_len_err;

   // An early s_last throws the partial frame away; a missing s_last on the
   // final word is flagged but the frame is still kept.
   assign w_abort   = w_xfer && s_last && !w_at_last;
   assign w_len_err = w_abort || (w_xfer && w_at_last && !s_last);

   // Length errors latch until reset so software can notice them later.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_err <= 1'b0;
      end else if (w_len_err) begin
         r_frame_err <= 1'b1;
      end
   end

   assign frame_err = r_frame_err;
`else
   logic w_unused_last;

   assign w_abort       = 1'b0;
   assign w_unused_last = s_last;
   assign frame_err     = 1'b0;
`endif

   // Next-state of the fill side. A frame completing and a frame being
   // released by the core can land in the same cycle and both must stick;
   // they always target different banks because a full write bank stalls
   // the stream.
   always_comb begin
      w_full_next    = r_full;
      w_wr_bank_next = r_wr_bank;
      w_wr_cnt_next  = r_wr_cnt;
      if (w_xfer) begin
         if (w_abort) begin
            w_wr_cnt_next = '0;
         end else if (w_at_last) begin
            w_full_next[r_wr_bank] = 1'b1;
            w_wr_cnt_next          = '0;
            w_wr_bank_next         = ~r_wr_bank;
         end else begin
            w_wr_cnt_next = r_wr_cnt + CNT_W'(1);
         end
      end
      if (w_release) begin
         w_full_next[r_rd_bank] = 1'b0;
      end
   end

   // Fill-side registers. s_ready is computed from the next-state flags so
   // it drops in the very cycle after the last free bank fills, and rises
   // the cycle after a bank is released.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_full    <= 2'b00;
         r_wr_bank <= 1'b0;
         r_wr_cnt  <= '0;
         r_s_ready <= 1'b1;
      end else begin
         r_full    <= w_full_next;
         r_wr_bank <= w_wr_bank_next;
         r_wr_cnt  <= w_wr_cnt_next;
         r_s_ready <= ~w_full_next[w_wr_bank_next];
      end
   end

   // Dispatch FSM: pick a full bank, pulse core_enable for one cycle, then
   // hold busy until the core reports done. core_done outside WAIT is
   // ignored on purpose.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= LD_IDLE;
         r_rd_bank     <= 1'b0;
         r_core_enable <= 1'b0;
         r_busy        <= 1'b0;
         r_frame_cnt   <= 16'd0;
      end else begin
         r_core_enable <= 1'b0;
         case (r_state)
            LD_IDLE: begin
               if (w_dispatch) begin
                  r_rd_bank     <= w_sel_bank;
                  r_core_enable <= 1'b1;
                  r_state       <= LD_START;
               end
            end
            LD_START: begin
               r_busy  <= 1'b1;
               r_state <= LD_WAIT;
            end
            LD_WAIT: begin
               if (core_done) begin
                  r_busy      <= 1'b0;
                  r_frame_cnt <= r_frame_cnt + 16'd1;
                  r_state     <= LD_IDLE;
               end
            end
            default: begin
               r_state <= LD_IDLE;
            end
         endcase
      end
   end

   // The image handed to the core is captured once, on the way into START.
   // This keeps img_out frozen through WAIT and stops it following the
   // stream while a bank is refilling.
   always_ff @(posedge clk) begin
      if (!rst && w_dispatch) begin
         r_img_out <= w_sel_bank ? w_img1 : w_img0;
      end
   end

   cnn_img_bank u_bank0 (
      .clk    (clk),
      .i_we   (w_xfer && !r_wr_bank),
      .i_addr (r_wr_cnt),
      .i_data (s_data),
      .o_img  (w_img0)
   );

   cnn_img_bank u_bank1 (
      .clk    (clk),
      .i_we   (w_xfer && r_wr_bank),
      .i_addr (r_wr_cnt),
      .i_data (s_data),
      .o_img  (w_img1)
   );

   assign s_ready     = r_s_ready;
   assign core_enable = r_core_enable;
   assign busy        = r_busy;
   assign frame_cnt   = r_frame_cnt;
   assign img_out     = r_img_out;

endmodule

// File: tb/tb_cnn_img_loader.sv
// ---------------------------------------------------------------------------
// tb_cnn_img_loader
// Directed bench for cnn_img_loader: single frame, ping-pong overlap,
// backpressure, reset mid-frame / mid-WAIT, spurious done and the s_last
// handling of the CNN_LOADER_LAST_CHECK_EN build.
// ---------------------------------------------------------------------------
module tb_cnn_img_loader;
   import cnn_pkg::*;

   localparam int IMG_W = IMG_PIXELS * DATA_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_last = 1'b0;
   logic [IMG_W-1:0]  img_out;
   logic              core_enable;
   logic              busy;
   logic [15:0]       frame_cnt;
   logic              frame_err;
   logic              doneAuto = 1'b0;
   logic              doneManual = 1'b0;
   logic              core_done;

   assign core_done = doneAuto | doneManual;

   int checkCount = 0;
   int passCount  = 0;
   int cyc        = 0;
   int lastAccept = 0;
   int stallCount = 0;
   int coreLat    = 10;
   bit coreAuto   = 1'b0;
   int pending    = 0;
   int enCount    = 0;
   int instab     = 0;
   int enCyc [4];
   logic [IMG_W-1:0] snap [4];
   logic [IMG_W-1:0] curImg;

   cnn_img_loader dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .img_out     (img_out),
      .core_enable (core_enable),
      .core_done   (core_done),
      .busy        (busy),
      .frame_cnt   (frame_cnt),
      .frame_err   (frame_err)
   );

   // Free-running clock and cycle index (cycle k lies between posedge k and k+1).
   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Core model: answers each core_enable with core_done coreLat cycles later.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         pending  = 0;
         doneAuto = 1'b0;
      end else begin
         if (pending > 0) begin
            pending--;
            doneAuto = (pending == 0);
         end else begin
            doneAuto = 1'b0;
         end
         if (core_enable && coreAuto) pending = coreLat;
      end
   end

   // Monitor: records each dispatch and any img_out movement while busy.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         enCount = 0;
         instab  = 0;
      end else if (core_enable) begin
         if (enCount < 4) begin
            enCyc[enCount] = cyc;
            snap[enCount]  = img_out;
         end
         enCount++;
         curImg = img_out;
      end else if (busy && (img_out !== curImg)) begin
         instab++;
      end
   end

   // Hang guard.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] pix(input logic [IMG_W-1:0] img, input int i);
      return img[i*DATA_W +: DATA_W];
   endfunction

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end else begin
         passCount++;
      end
   endtask

   // Offers one word at a negedge and waits (bounded) until it is accepted.
   task automatic applyStimulus(input logic [31:0] d, input logic lst);
      int waitCyc = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = lst;
      while (!s_ready && waitCyc < 3000) begin
         stallCount++;
         @(negedge clk);
         waitCyc++;
      end
      if (!s_ready) begin
         checkOutput("accept_timeout", 64'(0), 64'(1));
      end else begin
         lastAccept = cyc;
         @(negedge clk);
      end
   endtask

   task automatic streamFrames(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) applyStimulus(base + i, (i % 64) == 63);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic pulseDone();
      doneManual = 1'b1;
      @(negedge clk);
      doneManual = 1'b0;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst        = 1'b1;
      s_valid    = 1'b0;
      s_last     = 1'b0;
      doneManual = 1'b0;
      coreAuto   = 1'b0;
      repeat (2) @(negedge clk);
      rst        = 1'b0;
      stallCount = 0;
   endtask

   task automatic waitEn(input int target, input int budget, input string tag);
      int k = 0;
      while (enCount < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      checkOutput(tag, 64'(enCount), 64'(target));
   endtask

   task automatic waitFrames(input int target, input int budget, input string tag);
      int k = 0;
      while (int'(frame_cnt) < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      checkOutput(tag, 64'(frame_cnt), 64'(target));
   endtask

   initial begin
      // ---------------- reset state ----------------
      doReset();
      @(negedge clk);
      checkOutput("rst_s_ready", 64'(s_ready), 64'(1));
      checkOutput("rst_core_enable", 64'(core_enable), 64'(0));
      checkOutput("rst_busy", 64'(busy), 64'(0));
      checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'(0));
      checkOutput("rst_frame_err", 64'(frame_err), 64'(0));

      // ---------------- single frame ----------------
      $display("[TB] single frame");
      coreAuto = 1'b1;
      coreLat  = 10;
      streamFrames(32'h100, 64);
      waitEn(1, 50, "t1_enable");
      checkOutput("t1_latency", 64'(enCyc[0] - lastAccept), 64'(2));
      repeat (3) @(negedge clk);
      checkOutput("t1_busy", 64'(busy), 64'(1));
      checkOutput("t1_word5", 64'(pix(img_out, 5)), 64'h105);
      waitFrames(1, 50, "t1_frame_cnt");
      checkOutput("t1_busy_clear", 64'(busy), 64'(0));
      checkOutput("t1_stable", 64'(instab), 64'(0));
      checkOutput("t1_word0", 64'(pix(snap[0], 0)), 64'h100);
      checkOutput("t1_word63", 64'(pix(snap[0], 63)), 64'h13F);
      repeat (20) @(negedge clk);
      checkOutput("t1_one_pulse", 64'(enCount), 64'(1));

      // ---------------- ping-pong overlap ----------------
      $display("[TB] ping-pong overlap");
      doReset();
      coreAuto = 1'b1;
      coreLat  = 100;
      streamFrames(32'h200, 128);
      checkOutput("t2_no_stall", 64'(stallCount), 64'(0));
      waitEn(2, 400, "t2_enable2");
      checkOutput("t2_gap", 64'(enCyc[1] - enCyc[0]), 64'(102));
      checkOutput("t2_f1_word0", 64'(pix(snap[0], 0)), 64'h200);
      checkOutput("t2_f2_word0", 64'(pix(snap[1], 0)), 64'h240);
      checkOutput("t2_f2_word63", 64'(pix(snap[1], 63)), 64'h27F);
      waitFrames(2, 200, "t2_frame_cnt");
      checkOutput("t2_stable", 64'(instab), 64'(0));

      // ---------------- backpressure ----------------
      $display("[TB] backpressure");
      doReset();
      coreAuto = 1'b0;
      streamFrames(32'h300, 128);
      repeat (2) @(negedge clk);
      checkOutput("t3_ready_low", 64'(s_ready), 64'(0));
      checkOutput("t3_enable1", 64'(enCount), 64'(1));
      stallCount = 0;
      fork
         streamFrames(32'h380, 64);
         begin
            repeat (10) @(negedge clk);
            checkOutput("t3_stalled", 64'(s_ready), 64'(0));
            checkOutput("t3_cnt0", 64'(frame_cnt), 64'(0));
            pulseDone();
         end
      join
      checkOutput("t3_stall_seen", 64'(stallCount > 0), 64'(1));
      checkOutput("t3_cnt1", 64'(frame_cnt), 64'(1));
      waitEn(2, 20, "t3_enable2");
      pulseDone();
      waitFrames(2, 20, "t3_cnt2");
      waitEn(3, 50, "t3_enable3");
      checkOutput("t3_f2_word0", 64'(pix(snap[1], 0)), 64'h340);
      checkOutput("t3_f3_word0", 64'(pix(snap[2], 0)), 64'h380);
      checkOutput("t3_f3_word63", 64'(pix(snap[2], 63)), 64'h3BF);
      repeat (3) @(negedge clk);
      checkOutput("t3_wait_busy", 64'(busy), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pulseDone();
      repeat (3) @(negedge clk);
      checkOutput("t3_rst_cnt", 64'(frame_cnt), 64'(0));
      checkOutput("t3_rst_busy", 64'(busy), 64'(0));
      checkOutput("t3_rst_ready", 64'(s_ready), 64'(1));
      checkOutput("t3_rst_no_enable", 64'(enCount), 64'(0));

      // ---------------- reset mid-frame ----------------
      $display("[TB] reset mid-frame");
      doReset();
      coreAuto = 1'b1;
      coreLat  = 10;
      for (int i = 0; i < 30; i++) applyStimulus(32'hDEAD0000 + i, 1'b0);
      s_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      streamFrames(32'h400, 64);
      waitEn(1, 50, "t4_enable");
      checkOutput("t4_word0", 64'(pix(snap[0], 0)), 64'h400);
      checkOutput("t4_word29", 64'(pix(snap[0], 29)), 64'h41D);
      checkOutput("t4_word63", 64'(pix(snap[0], 63)), 64'h43F);
      waitFrames(1, 50, "t4_frame_cnt");
      repeat (20) @(negedge clk);
      checkOutput("t4_one_pulse", 64'(enCount), 64'(1));

      // ---------------- spurious done ----------------
      $display("[TB] spurious done");
      pulseDone();
      repeat (5) @(negedge clk);
      checkOutput("t5_cnt", 64'(frame_cnt), 64'(1));
      checkOutput("t5_busy", 64'(busy), 64'(0));
      checkOutput("t5_no_enable", 64'(enCount), 64'(1));
      streamFrames(32'h500, 64);
      waitEn(2, 50, "t5_enable");
      checkOutput("t5_word7", 64'(pix(snap[1], 7)), 64'h507);
      waitFrames(2, 50, "t5_frame_cnt");

`ifdef CNN_LOADER_LAST_CHECK_EN
      // ---------------- early s_last ----------------
      $display("[TB] early s_last");
      doReset();
      coreAuto = 1'b1;
      coreLat  = 10;
      for (int i = 0; i < 41; i++) applyStimulus(32'h600 + i, i == 40);
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("t6_err", 64'(frame_err), 64'(1));
      checkOutput("t6_no_enable", 64'(enCount), 64'(0));
      checkOutput("t6_ready", 64'(s_ready), 64'(1));
      streamFrames(32'h700, 64);
      waitEn(1, 50, "t6_enable");
      checkOutput("t6_word0", 64'(pix(snap[0], 0)), 64'h700);
      checkOutput("t6_word63", 64'(pix(snap[0], 63)), 64'h73F);
      waitFrames(1, 50, "t6_frame_cnt");
      checkOutput("t6_err_sticky", 64'(frame_err), 64'(1));
`else
      // ---------------- s_last ignored ----------------
      $display("[TB] s_last ignored");
      doReset();
      coreAuto = 1'b1;
      coreLat  = 10;
      for (int i = 0; i < 64; i++) applyStimulus(32'h800 + i, i == 10);
      s_valid = 1'b0;
      s_last  = 1'b0;
      waitEn(1, 50, "t6_enable");
      checkOutput("t6_word10", 64'(pix(snap[0], 10)), 64'h80A);
      checkOutput("t6_word63", 64'(pix(snap[0], 63)), 64'h83F);
      checkOutput("t6_err_low", 64'(frame_err), 64'(0));
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
